// File: rtl/dcache_pkg.sv
//------------------------------------------------------------------------------
// Module : dcache_pkg
// Brief  : Shared field widths and FSM state encoding for the data cache.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

    localparam int C_TAG_W     = 22;
    localparam int C_IDX_W     = 5;
    localparam int C_OFF_W     = 5;
    localparam int C_WORD_W    = 32;
    localparam int C_LINE_BITS = 256;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB_REQ  = 3'd1,
        S_WB_WAIT = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_REFILL  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dcache_sram.sv
//------------------------------------------------------------------------------
// Module : dcache_sram
// Brief  : Tag/valid/dirty and line storage, one synchronous write port,
//          combinational read. Reset clears only valid and dirty bits.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINE_BITS = C_LINE_BITS,
    parameter int NUM_LINES = 32,
    parameter int TAG_W     = C_TAG_W,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [IDX_W-1:0]     i_waddr,
    input  logic                 i_wvalid,
    input  logic                 i_wdirty,
    input  logic [TAG_W-1:0]     i_wtag,
    input  logic [LINE_BITS-1:0] i_wdata,
    input  logic [IDX_W-1:0]     i_raddr,
    output logic                 o_rvalid,
    output logic                 o_rdirty,
    output logic [TAG_W-1:0]     o_rtag,
    output logic [LINE_BITS-1:0] o_rdata
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_waddr] <= i_wvalid;
            r_dirty[i_waddr] <= i_wdirty;
        end
    end

    // Tag and data survive reset; valid alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_waddr]  <= i_wtag;
            r_data[i_waddr] <= i_wdata;
        end
    end

    assign o_rvalid = r_valid[i_raddr];
    assign o_rdirty = r_dirty[i_raddr];
    assign o_rtag   = r_tag[i_raddr];
    assign o_rdata  = r_data[i_raddr];

endmodule

`default_nettype wire

// File: rtl/dcache_controller.sv
//------------------------------------------------------------------------------
// Module : dcache_controller
// Brief  : Direct-mapped write-back, write-allocate data cache controller.
//          Define DCACHE_STATS_EN to build the saturating hit/miss counters.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINE_BITS = C_LINE_BITS,
    parameter int NUM_LINES = 1 << C_IDX_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [15:0]          hit_cnt_o,
    output logic [15:0]          miss_cnt_o
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - IDX_W - C_OFF_W;
    localparam int WSEL_W = C_OFF_W - 2;

    state_t               state;
    logic [TAG_W-1:0]     r_req_tag;
    logic [IDX_W-1:0]     r_req_idx;
    logic                 r_mem_en;
    logic                 r_mem_write;
    logic [31:0]          r_mem_addr;
    logic [LINE_BITS-1:0] r_mem_data;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [WSEL_W-1:0]    w_wsel;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_vld;
    logic                 w_dirty;
    logic [TAG_W-1:0]     w_vtag;
    logic [LINE_BITS-1:0] w_line;
    logic [LINE_BITS-1:0] w_merged;
    logic                 w_we;
    logic [IDX_W-1:0]     w_widx;
    logic                 w_wdirty;
    logic [TAG_W-1:0]     w_wtag;
    logic [LINE_BITS-1:0] w_wdata;
    logic                 w_unused;

    assign w_idx    = p1_addr_i[C_OFF_W +: IDX_W];
    assign w_tag    = p1_addr_i[31 -: TAG_W];
    assign w_wsel   = p1_addr_i[C_OFF_W-1:2];
    assign w_req    = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit    = (state == S_IDLE) && w_req && w_vld && (w_vtag == w_tag);
    assign w_unused = &{1'b0, p1_addr_i[1:0]};

    dcache_sram #(
        .LINE_BITS (LINE_BITS),
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W)
    ) u_sram (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_we     (w_we),
        .i_waddr  (w_widx),
        .i_wvalid (1'b1),
        .i_wdirty (w_wdirty),
        .i_wtag   (w_wtag),
        .i_wdata  (w_wdata),
        .i_raddr  (w_idx),
        .o_rvalid (w_vld),
        .o_rdirty (w_dirty),
        .o_rtag   (w_vtag),
        .o_rdata  (w_line)
    );

    // Write port serves either a store hit (merge one word) or a refill.
    always_comb begin
        w_merged = w_line;
        w_merged[w_wsel*C_WORD_W +: C_WORD_W] = p1_data_i;
        w_we     = 1'b0;
        w_widx   = w_idx;
        w_wdirty = 1'b1;
        w_wtag   = w_tag;
        w_wdata  = w_merged;
        if (!rst_i) begin
            if (w_hit && p1_MemWrite_i) begin
                w_we = 1'b1;
            end else if (state == S_RD_WAIT && mem_ack_i) begin
                w_we     = 1'b1;
                w_widx   = r_req_idx;
                w_wdirty = 1'b0;
                w_wtag   = r_req_tag;
                w_wdata  = mem_data_i;
            end
        end
    end

    assign p1_data_o    = w_hit ? w_line[w_wsel*C_WORD_W +: C_WORD_W] : 32'h0;
    assign p1_stall_o   = (state != S_IDLE) || (w_req && !w_hit);
    assign mem_enable_o = r_mem_en;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_data  <= '0;
            r_req_tag   <= '0;
            r_req_idx   <= '0;
        end else begin
            r_mem_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_req_tag <= w_tag;
                        r_req_idx <= w_idx;
                        r_mem_en  <= 1'b1;
                        if (w_vld && w_dirty) begin
                            state       <= S_WB_REQ;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {w_vtag, w_idx, {C_OFF_W{1'b0}}};
                            r_mem_data  <= w_line;
                        end else begin
                            state       <= S_RD_REQ;
                            r_mem_write <= 1'b0;
                            r_mem_addr  <= {w_tag, w_idx, {C_OFF_W{1'b0}}};
                        end
                    end
                end
                S_WB_REQ:  state <= S_WB_WAIT;
                S_WB_WAIT: begin
                    if (mem_ack_i) begin
                        state       <= S_RD_REQ;
                        r_mem_en    <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {r_req_tag, r_req_idx, {C_OFF_W{1'b0}}};
                    end
                end
                S_RD_REQ:  state <= S_RD_WAIT;
                S_RD_WAIT: if (mem_ack_i) state <= S_REFILL;
                S_REFILL:  state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;
    logic        r_after_refill;

    // The first IDLE cycle after a refill completes a request already counted as a miss.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_cnt      <= 16'h0;
            r_miss_cnt     <= 16'h0;
            r_after_refill <= 1'b0;
        end else begin
            r_after_refill <= (state == S_REFILL);
            if (w_hit && !r_after_refill && r_hit_cnt != 16'hFFFF)
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (state == S_IDLE && w_req && !w_hit && r_miss_cnt != 16'hFFFF)
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = 16'h0;
    assign miss_cnt_o = 16'h0;
`endif

endmodule

`default_nettype wire
